// File: rtl/piso_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
//   Shared types and helpers for the parallel-in / serial-out transmitter.
//   - state_t   : transmitter FSM states (IDLE, SHIFT)
//   - frame_len : number of serial bits per frame for a given data width
// Optional feature macro: PISO_PARITY_EN
//   When defined, every frame carries one extra even-parity bit after the
//   data bits, so a frame is width+1 bits long. When undefined, a frame is
//   exactly width bits and no parity logic exists anywhere.
// ---------------------------------------------------------------------------
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Serial bits per frame: data bits, plus the parity bit when enabled.
  function automatic int frame_len(input int width);
`ifdef PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage : piso_pkg

// File: rtl/piso_bit_counter.sv
// ---------------------------------------------------------------------------
// piso_bit_counter
//   Tracks which frame bit is currently on the serial line.
//   The count is cleared when a new word is accepted and advances by one for
//   every bit that is not the last bit of the frame, so it never wraps
//   within a frame.
// Ports
//   clock       in   rising-edge clock
//   reset_n     in   asynchronous active-low reset (count -> 0)
//   clear       in   a word is accepted at this edge; next count is 0
//   advance     in   move on to the next frame bit at this edge
//   last_bit    out  the current bit is the last bit of the frame
//   penult_bit  out  the current bit is the one before the last bit
// ---------------------------------------------------------------------------
module piso_bit_counter #(
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic advance,
  output logic last_bit,
  output logic penult_bit
);

  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] PENULT_IDX = CNT_W'(FRAME_LEN - 2);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (advance) begin
      count <= count + CNT_W'(1);
    end
  end

  // penult_bit lets the FSM register frame_done/load_ready one cycle early,
  // so those outputs line up exactly with the last bit.
  assign last_bit   = (count == LAST_IDX);
  assign penult_bit = (count == PENULT_IDX);

endmodule : piso_bit_counter

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//   Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word over a
//   valid/ready handshake and sends it one bit per clock on serial_out,
//   qualified by serial_valid. frame_done pulses with the last frame bit.
//   A new word may be accepted during the last bit of the current frame,
//   giving back-to-back frames with no idle gap.
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
// Ports
//   clock         in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   load_valid    in   load_data holds a word to send
//   load_ready    out  a word is accepted at the next edge if load_valid
//   load_data     in   parallel word (sampled only at accept)
//   serial_out    out  serial bit stream (0 when idle)
//   serial_valid  out  serial_out carries a frame bit this cycle
//   frame_done    out  one-cycle pulse on the last frame bit
// Optional feature macro: PISO_PARITY_EN
//   Appends an even-parity bit (^load_data) after the data bits.
// ---------------------------------------------------------------------------
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_done
);

  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam int CNT_W     = $clog2(WIDTH + 2);

  state_t               state;
  logic [FRAME_LEN-2:0] rest;
  logic [FRAME_LEN-1:0] ordered;
  logic                 accept;
  logic                 advance;
  logic                 last_bit;
  logic                 penult_bit;

  assign accept  = load_valid && load_ready;
  assign advance = (state == SHIFT) && !last_bit;

  // Arrange the incoming word in transmit order: ordered[0] goes out first.
  always_comb begin
    ordered = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST != 0) begin
        ordered[i] = load_data[WIDTH-1-i];
      end else begin
        ordered[i] = load_data[i];
      end
    end
`ifdef PISO_PARITY_EN
    ordered[WIDTH] = ^load_data;
`endif
  end

  piso_bit_counter #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W)
  ) u_bit_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (accept),
    .advance    (advance),
    .last_bit   (last_bit),
    .penult_bit (penult_bit)
  );

  // FSM, shift register and all registered outputs. The first frame bit is
  // placed straight into serial_out at accept; rest holds the bits still to
  // come. frame_done and load_ready are computed for the cycle being entered,
  // so they are high exactly while the last bit is on the line (load_ready
  // also in IDLE).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rest         <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      frame_done   <= 1'b0;
      load_ready   <= 1'b1;
    end else if (accept) begin
      state        <= SHIFT;
      rest         <= ordered[FRAME_LEN-1:1];
      serial_out   <= ordered[0];
      serial_valid <= 1'b1;
      frame_done   <= 1'b0;
      load_ready   <= 1'b0;
    end else if (state == SHIFT && !last_bit) begin
      rest         <= rest >> 1;
      serial_out   <= rest[0];
      serial_valid <= 1'b1;
      frame_done   <= penult_bit;
      load_ready   <= penult_bit;
    end else if (state == SHIFT) begin
      state        <= IDLE;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      frame_done   <= 1'b0;
      load_ready   <= 1'b1;
    end else begin
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      frame_done   <= 1'b0;
      load_ready   <= 1'b1;
    end
  end

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
//   Self-checking bench for piso_serializer with WIDTH=4. Two instances run
//   side by side on shared inputs: one MSB-first, one LSB-first. A queue-based
//   reference model predicts every output each cycle; a table of words with
//   hand-derived bit streams, a few directed sequences and a randomized phase
//   drive the inputs. Small deserializer stand-ins emulate shift_register_4bit
//   for the loopback check. Define PISO_PARITY_EN to test the parity build.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } item_t;

  typedef struct {
    logic [3:0] data;
    logic [4:0] exp_msb;
    logic [4:0] exp_lsb;
  } vec_t;

  logic       clock;
  logic       reset_n;
  logic       load_valid;
  logic [3:0] load_data;
  logic       load_ready_m, serial_out_m, serial_valid_m, frame_done_m;
  logic       load_ready_l, serial_out_l, serial_valid_l, frame_done_l;

  int n_cmp = 0;
  int n_bad = 0;

  item_t mq_m[$];
  item_t mq_l[$];
  bit    accepted_last = 1'b0;

  logic [3:0] q_m, q_l;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
    .clock        (clock),
    .reset_n      (reset_n),
    .load_valid   (load_valid),
    .load_ready   (load_ready_m),
    .load_data    (load_data),
    .serial_out   (serial_out_m),
    .serial_valid (serial_valid_m),
    .frame_done   (frame_done_m)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
    .clock        (clock),
    .reset_n      (reset_n),
    .load_valid   (load_valid),
    .load_ready   (load_ready_l),
    .load_data    (load_data),
    .serial_out   (serial_out_l),
    .serial_valid (serial_valid_l),
    .frame_done   (frame_done_l)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bit i of a frame for word d: data bits in the requested order, then parity.
  function automatic logic frame_bit(input logic [3:0] d, input bit msb, input int i);
    if (i >= 4) return ^d;
    return msb ? d[3-i] : d[i];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending frame bits per instance. The head is
  // the bit on the line; a word is taken whenever at most one bit is pending.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mq_m.delete();
      mq_l.delete();
      accepted_last = 1'b0;
    end else begin
      accepted_last = load_valid && (mq_m.size() <= 1);
      if (mq_m.size() > 0) void'(mq_m.pop_front());
      if (mq_l.size() > 0) void'(mq_l.pop_front());
      if (accepted_last) begin
        for (int i = 0; i < FL; i++) begin
          mq_m.push_back('{b: frame_bit(load_data, 1'b1, i), last: (i == FL - 1)});
          mq_l.push_back('{b: frame_bit(load_data, 1'b0, i), last: (i == FL - 1)});
        end
      end
    end
  end

  // Stand-ins for shift_register_4bit receiving each stream.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_m <= 4'h0;
      q_l <= 4'h0;
    end else begin
      if (serial_valid_m) q_m <= {q_m[2:0], serial_out_m};
      if (serial_valid_l) q_l <= {serial_out_l, q_l[3:1]};
    end
  end

  // Every cycle, compare all outputs of both instances against the model.
  always @(negedge clock) begin
    check("m.serial_valid", 32'(serial_valid_m), 32'(mq_m.size() > 0));
    check("m.serial_out",   32'(serial_out_m),   32'((mq_m.size() > 0) ? mq_m[0].b : 1'b0));
    check("m.frame_done",   32'(frame_done_m),   32'((mq_m.size() > 0) ? mq_m[0].last : 1'b0));
    check("m.load_ready",   32'(load_ready_m),   32'(mq_m.size() <= 1));
    check("l.serial_valid", 32'(serial_valid_l), 32'(mq_l.size() > 0));
    check("l.serial_out",   32'(serial_out_l),   32'((mq_l.size() > 0) ? mq_l[0].b : 1'b0));
    check("l.frame_done",   32'(frame_done_l),   32'((mq_l.size() > 0) ? mq_l[0].last : 1'b0));
    check("l.load_ready",   32'(load_ready_l),   32'(mq_l.size() <= 1));
  end

  // Send one table word from IDLE and compare the captured streams.
  task automatic applyStimulus(input vec_t v);
    logic [4:0] got_m, got_l, done_v;
    int         nvalid;
    got_m = '0; got_l = '0; done_v = '0; nvalid = 0;
    @(negedge clock);
    load_valid = 1'b1;
    load_data  = v.data;
    for (int i = 0; i <= FL; i++) begin
      @(negedge clock);
      if (i == 0) load_valid = 1'b0;
      if (i < FL) begin
        got_m  = {got_m[3:0], serial_out_m};
        got_l  = {got_l[3:0], serial_out_l};
        done_v = {done_v[3:0], frame_done_m};
        nvalid += int'(serial_valid_m) + int'(serial_valid_l);
      end
      if (i == 4) begin
        check("loopback_msb", 32'(q_m), 32'(v.data));
        check("loopback_lsb", 32'(q_l), 32'(v.data));
      end
      if (i == FL) begin
        check("idle_after_frame", 32'({serial_valid_m, serial_valid_l, serial_out_m, serial_out_l}), 32'h0);
      end
    end
    check("stream_msb", 32'(got_m), 32'(v.exp_msb));
    check("stream_lsb", 32'(got_l), 32'(v.exp_lsb));
    check("done_pattern", 32'(done_v), 32'h1);
    check("valid_count", 32'(nvalid), 32'(2 * FL));
  endtask

  task automatic checkOutput(input string name, input logic [9:0] got, input logic [9:0] exp);
    check(name, 32'(got), 32'(exp));
  endtask

  vec_t vecs[6];

  initial begin
    logic [9:0] cap;
    int         nv;

    reset_n    = 1'b0;
    load_valid = 1'b0;
    load_data  = 4'h0;

`ifdef PISO_PARITY_EN
    vecs[0] = '{4'b1011, 5'b10111, 5'b11011};
    vecs[1] = '{4'b0111, 5'b01111, 5'b11101};
    vecs[2] = '{4'b1010, 5'b10100, 5'b01010};
    vecs[3] = '{4'b0000, 5'b00000, 5'b00000};
    vecs[4] = '{4'b1111, 5'b11110, 5'b11110};
    vecs[5] = '{4'b0001, 5'b00011, 5'b10001};
`else
    vecs[0] = '{4'b1011, 5'b01011, 5'b01101};
    vecs[1] = '{4'b0111, 5'b00111, 5'b01110};
    vecs[2] = '{4'b1010, 5'b01010, 5'b00101};
    vecs[3] = '{4'b0000, 5'b00000, 5'b00000};
    vecs[4] = '{4'b1111, 5'b01111, 5'b01111};
    vecs[5] = '{4'b0001, 5'b00001, 5'b01000};
`endif

    // Reset held for two cycles, then released between edges.
    @(negedge clock);
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    check("reset_state", 32'({load_ready_m, serial_valid_m, serial_out_m, frame_done_m}), 32'h8);

    for (int k = 0; k < 6; k++) applyStimulus(vecs[k]);

    // Back-to-back: 4'hA then 4'h5 with load_valid held high throughout.
    @(negedge clock);
    load_valid = 1'b1;
    load_data  = 4'hA;
    cap = '0; nv = 0;
    for (int i = 0; i < 2 * FL; i++) begin
      @(negedge clock);
      if (i == 0) load_data = 4'h5;
      if (i == FL) load_valid = 1'b0;
      cap = {cap[8:0], serial_out_m};
      nv += int'(serial_valid_m);
    end
`ifdef PISO_PARITY_EN
    checkOutput("b2b_stream", cap, 10'b10100_01010);
`else
    checkOutput("b2b_stream", cap, 10'b1010_0101);
`endif
    check("b2b_contiguous", 32'(nv), 32'(2 * FL));
    @(negedge clock);
    check("b2b_idle", 32'(serial_valid_m), 32'h0);

    // Busy: 4'hF offered at count=1 of a 4'h0 frame, held until accepted.
    @(negedge clock);
    load_valid = 1'b1;
    load_data  = 4'h0;
    cap = '0;
    for (int i = 0; i < 2 * FL; i++) begin
      @(negedge clock);
      if (i == 0) load_valid = 1'b0;
      if (i == 1) begin
        load_valid = 1'b1;
        load_data  = 4'hF;
      end
      if (i == FL) load_valid = 1'b0;
      cap = {cap[8:0], serial_out_m};
    end
`ifdef PISO_PARITY_EN
    checkOutput("busy_stream", cap, 10'b00000_11110);
`else
    checkOutput("busy_stream", cap, 10'b0000_1111);
`endif
    @(negedge clock);

    // Reset mid-frame after two bits: outputs drop at once, no frame_done.
    @(negedge clock);
    load_valid = 1'b1;
    load_data  = 4'b1011;
    @(negedge clock);
    load_valid = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_outputs", 32'({serial_valid_m, serial_valid_l, serial_out_m, serial_out_l}), 32'h0);
    check("midreset_done", 32'({frame_done_m, frame_done_l}), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("midreset_no_done", 32'({frame_done_m, frame_done_l}), 32'h0);
    end
    #2 reset_n = 1'b1;
    @(negedge clock);
    check("after_reset_ready", 32'({load_ready_m, load_ready_l, serial_valid_m}), 32'h6);

    // Randomized phase: the sender holds a word until the model says it was taken.
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      if (!(load_valid && !accepted_last)) begin
        load_valid = ($urandom_range(0, 3) != 0);
        load_data  = 4'($urandom);
      end
    end
    load_valid = 1'b0;
    for (int c = 0; c < 2 * FL; c++) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_piso_serializer
